// File: rtl/fpga_serializer.sv
// Upstream PC-word serializer: merges heartbeat time reports and spike-filter
// outputs into a stream of 32-bit PC words, each message sent as LO then HI.
//
// state | meaning
// IDLE  | no message in flight; arbitrates heartbeat (priority) vs spike filter
// HB_LO | presenting heartbeat low word
// HB_HI | presenting heartbeat high word
// SF_LO | presenting spike-filter low word
// SF_HI | presenting spike-filter high word
module fpga_serializer #(
   parameter int NPCcode    = 8,
   parameter int NPCdata    = 24,
   parameter int Ntime      = 48,
   parameter int N_SF_filts = 10,
   parameter int N_SF_state = 27,
   parameter logic [NPCcode-1:0] CODE_HB_LO = 8'd64,
   parameter logic [NPCcode-1:0] CODE_HB_HI = 8'd65,
   parameter logic [NPCcode-1:0] CODE_SF_LO = 8'd66,
   parameter logic [NPCcode-1:0] CODE_SF_HI = 8'd67
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  send_HB_up_pulse,
   input  logic [Ntime-1:0]      time_elapsed,
   input  logic                  SF_in_v,
   input  logic [N_SF_filts-1:0] SF_in_filt_idx,
   input  logic [N_SF_state-1:0] SF_in_filt_state,
   output logic                  SF_in_a,
   output logic                  PC_out_v,
   output logic [NPCcode-1:0]    PC_out_code,
   output logic [NPCdata-1:0]    PC_out_payload,
   input  logic                  PC_out_a
);

   localparam int NW = 2 * NPCdata;

   typedef enum logic [2:0] {IDLE, HB_LO, HB_HI, SF_LO, SF_HI} state_t;

   state_t                  state, state_nxt;
   logic                    hb_pending, hb_pending_nxt;
   logic [Ntime-1:0]        hb_time, hb_time_nxt;
   logic [N_SF_filts-1:0]   sf_idx, sf_idx_nxt;
   logic [N_SF_state-1:0]   sf_state, sf_state_nxt;
   logic                    out_v_nxt;
   logic [NPCcode-1:0]      out_code_nxt;
   logic [NPCdata-1:0]      out_payload_nxt;
   logic [NW-1:0]           hb_word, sf_word;
   logic                    xfer, hb_req, load;

   assign xfer    = PC_out_v & PC_out_a;
   assign hb_req  = send_HB_up_pulse | hb_pending;
   assign hb_word = NW'(hb_time_nxt);
   assign sf_word = NW'({sf_idx_nxt, sf_state_nxt});
   // Output registers only reload when a new word is due, so a stalled word stays frozen.
   assign load    = (state == IDLE) | xfer;

   always_comb begin
      state_nxt      = state;
      hb_pending_nxt = hb_pending;
      hb_time_nxt    = hb_time;
      sf_idx_nxt     = sf_idx;
      sf_state_nxt   = sf_state;
      SF_in_a        = 1'b0;
      case (state)
         IDLE: begin
            if (hb_req) begin
               state_nxt      = HB_LO;
               hb_pending_nxt = 1'b0;
               if (send_HB_up_pulse) hb_time_nxt = time_elapsed;
            end else if (SF_in_v) begin
               SF_in_a      = reset;
               sf_idx_nxt   = SF_in_filt_idx;
               sf_state_nxt = SF_in_filt_state;
               state_nxt    = SF_LO;
            end
         end
         HB_LO:   if (xfer) state_nxt = HB_HI;
         HB_HI:   if (xfer) state_nxt = IDLE;
         SF_LO:   if (xfer) state_nxt = SF_HI;
         SF_HI:   if (xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && send_HB_up_pulse) begin
         hb_pending_nxt = 1'b1;
         hb_time_nxt    = time_elapsed;
      end
   end

   always_comb begin
      out_v_nxt       = 1'b0;
      out_code_nxt    = '0;
      out_payload_nxt = '0;
      case (state_nxt)
         HB_LO: begin
            out_v_nxt       = 1'b1;
            out_code_nxt    = CODE_HB_LO;
            out_payload_nxt = hb_word[NPCdata-1:0];
         end
         HB_HI: begin
            out_v_nxt       = 1'b1;
            out_code_nxt    = CODE_HB_HI;
            out_payload_nxt = hb_word[NW-1:NPCdata];
         end
         SF_LO: begin
            out_v_nxt       = 1'b1;
            out_code_nxt    = CODE_SF_LO;
            out_payload_nxt = sf_word[NPCdata-1:0];
         end
         SF_HI: begin
            out_v_nxt       = 1'b1;
            out_code_nxt    = CODE_SF_HI;
            out_payload_nxt = sf_word[NW-1:NPCdata];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         hb_pending     <= 1'b0;
         hb_time        <= '0;
         sf_idx         <= '0;
         sf_state       <= '0;
         PC_out_v       <= 1'b0;
         PC_out_code    <= '0;
         PC_out_payload <= '0;
      end else begin
         state      <= state_nxt;
         hb_pending <= hb_pending_nxt;
         hb_time    <= hb_time_nxt;
         sf_idx     <= sf_idx_nxt;
         sf_state   <= sf_state_nxt;
         if (load) begin
            PC_out_v       <= out_v_nxt;
            PC_out_code    <= out_code_nxt;
            PC_out_payload <= out_payload_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fpga_serializer.sv
// Directed bench for fpga_serializer: hand-computed PC words, a transfer
// monitor with stall-stability checks, and a small random merge scoreboard.
module tb_fpga_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        send_HB_up_pulse;
   logic [47:0] time_elapsed;
   logic        SF_in_v;
   logic [9:0]  SF_in_filt_idx;
   logic [26:0] SF_in_filt_state;
   logic        SF_in_a;
   logic        PC_out_v;
   logic [7:0]  PC_out_code;
   logic [23:0] PC_out_payload;
   logic        PC_out_a;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int sink_mode = 0;
   bit hb_done;

   logic [31:0] words[$];
   logic [36:0] sf_q[$];
   logic [47:0] hb_q[$];
   bit          stalled = 0;
   logic [31:0] stall_word;

   fpga_serializer dut (
      .clk              (clk),
      .reset            (reset),
      .send_HB_up_pulse (send_HB_up_pulse),
      .time_elapsed     (time_elapsed),
      .SF_in_v          (SF_in_v),
      .SF_in_filt_idx   (SF_in_filt_idx),
      .SF_in_filt_state (SF_in_filt_state),
      .SF_in_a          (SF_in_a),
      .PC_out_v         (PC_out_v),
      .PC_out_code      (PC_out_code),
      .PC_out_payload   (PC_out_payload),
      .PC_out_a         (PC_out_a)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         if (stalled) check("stall_stable", {PC_out_v, PC_out_code, PC_out_payload}, {1'b1, stall_word});
         if (PC_out_v && PC_out_a) words.push_back({PC_out_code, PC_out_payload});
         if (SF_in_v && SF_in_a) sf_q.push_back({SF_in_filt_idx, SF_in_filt_state});
         stalled    = PC_out_v && !PC_out_a;
         stall_word = {PC_out_code, PC_out_payload};
      end else begin
         stalled = 0;
      end
   end

   initial begin
      PC_out_a = 1'b1;
      forever begin
         @(negedge clk);
         case (sink_mode)
            0:       PC_out_a = 1'b1;
            1:       PC_out_a = ($urandom_range(0, 2) == 0);
            default: PC_out_a = 1'b0;
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_all();
      words.delete();
      sf_q.delete();
      hb_q.delete();
   endtask

   task automatic wait_words(input int n);
      for (int i = 0; i < 400 && words.size() < n; i++) @(negedge clk);
      check("word_count", words.size(), n);
   endtask

   task automatic pulse_hb(input logic [47:0] t);
      @(negedge clk);
      time_elapsed     = t;
      send_HB_up_pulse = 1'b1;
      @(negedge clk);
      send_HB_up_pulse = 1'b0;
   endtask

   task automatic sf_send(input logic [9:0] idx, input logic [26:0] st);
      bit done = 0;
      @(negedge clk);
      SF_in_v          = 1'b1;
      SF_in_filt_idx   = idx;
      SF_in_filt_state = st;
      for (int i = 0; i < 400; i++) begin
         #1;
         if (SF_in_a) begin
            done = 1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      SF_in_v = 1'b0;
      if (!done) check("sf_accept_timeout", 0, 1);
   endtask

   task automatic check_words(input string tag, input logic [31:0] exp[4], input int n);
      for (int i = 0; i < n; i++) begin
         if (words.size() == 0) check({tag, "_missing"}, 0, 1);
         else check(tag, words.pop_front(), exp[i]);
      end
   endtask

   initial begin
      logic [31:0] exp[4];
      logic [31:0] lo, hi;
      int          acc_words;

      reset            = 1'b0;
      send_HB_up_pulse = 1'b0;
      time_elapsed     = '0;
      SF_in_v          = 1'b1;
      SF_in_filt_idx   = 10'h155;
      SF_in_filt_state = 27'h1234567;

      // reset state, with SF_in_v high to confirm the accept stays low
      repeat (3) @(negedge clk);
      check("rst_v", PC_out_v, 0);
      check("rst_code", PC_out_code, 0);
      check("rst_payload", PC_out_payload, 0);
      check("rst_sf_a", SF_in_a, 0);
      SF_in_v = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_v", PC_out_v, 0);
      check("idle_sf_a", SF_in_a, 0);
      check("idle_words", words.size(), 0);

      // single heartbeat
      clear_all();
      @(negedge clk);
      time_elapsed     = 48'h0000_0100_0005;
      send_HB_up_pulse = 1'b1;
      @(negedge clk);
      send_HB_up_pulse = 1'b0;
      check("hb_latency_v", PC_out_v, 1);
      check("hb_latency_code", PC_out_code, 8'd64);
      check("hb_latency_payload", PC_out_payload, 24'h000005);
      wait_words(2);
      check("hb_v_drop", PC_out_v, 0);
      repeat (10) @(negedge clk);
      check("hb_once", words.size(), 2);
      exp = '{{8'd64, 24'h000005}, {8'd65, 24'h000001}, 32'h0, 32'h0};
      check_words("hb_word", exp, 2);

      // all-ones spike-filter word with a stuttering sink
      clear_all();
      sink_mode = 1;
      sf_send(10'h3FF, 27'h7FFFFFF);
      wait_words(2);
      sink_mode = 0;
      repeat (5) @(negedge clk);
      check("sf_accept_once", sf_q.size(), 1);
      exp = '{{8'd66, 24'hFFFFFF}, {8'd67, 24'h001FFF}, 32'h0, 32'h0};
      check_words("sf_word", exp, 2);

      // heartbeat and SF on the same IDLE edge: heartbeat first
      clear_all();
      @(negedge clk);
      time_elapsed     = 48'hABCDEF_123456;
      send_HB_up_pulse = 1'b1;
      SF_in_v          = 1'b1;
      SF_in_filt_idx   = 10'd1;
      SF_in_filt_state = 27'd2;
      #1;
      check("prio_sf_a_low", SF_in_a, 0);
      @(negedge clk);
      send_HB_up_pulse = 1'b0;
      acc_words = -1;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (SF_in_a) begin
            acc_words = words.size();
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      SF_in_v = 1'b0;
      check("prio_sf_after_hb", acc_words, 2);
      wait_words(4);
      exp = '{{8'd64, 24'h123456}, {8'd65, 24'hABCDEF}, {8'd66, 24'h000002}, {8'd67, 24'h000008}};
      check_words("prio_word", exp, 4);

      // two pulses during a stalled SF message coalesce to the later time
      clear_all();
      sink_mode = 2;
      sf_send(10'd5, 27'd9);
      pulse_hb(48'd7);
      repeat (3) @(negedge clk);
      pulse_hb(48'd8);
      repeat (3) @(negedge clk);
      sink_mode = 0;
      wait_words(4);
      repeat (20) @(negedge clk);
      check("coalesce_count", words.size(), 4);
      exp = '{{8'd66, 24'h000009}, {8'd67, 24'h000028}, {8'd64, 24'h000008}, {8'd65, 24'h000000}};
      check_words("coalesce_word", exp, 4);

      // random merge
      clear_all();
      sink_mode = 1;
      hb_done   = 0;
      fork
         begin
            for (int k = 0; k < 15; k++) begin
               repeat (63) @(negedge clk);
               @(negedge clk);
               time_elapsed     = {16'hBEEF, 32'(cyc)};
               send_HB_up_pulse = 1'b1;
               hb_q.push_back(time_elapsed);
               @(negedge clk);
               send_HB_up_pulse = 1'b0;
            end
            hb_done = 1;
         end
         begin
            while (!hb_done) begin
               repeat ($urandom_range(0, 10)) @(negedge clk);
               sf_send(10'($urandom), 27'($urandom));
            end
         end
      join
      sink_mode = 0;
      repeat (100) @(negedge clk);
      check("rnd_hb_count", hb_q.size(), 15);
      while (words.size() >= 2) begin
         lo = words.pop_front();
         hi = words.pop_front();
         check("rnd_pair_code", hi[31:24], lo[31:24] + 8'd1);
         if (lo[31:24] == 8'd64) begin
            if (hb_q.size() == 0) check("rnd_hb_extra", 1, 0);
            else check("rnd_hb_time", {hi[23:0], lo[23:0]}, hb_q.pop_front());
         end else if (lo[31:24] == 8'd66) begin
            check("rnd_sf_pad", hi[23:13], 0);
            if (sf_q.size() == 0) check("rnd_sf_extra", 1, 0);
            else check("rnd_sf_data", {hi[12:0], lo[23:0]}, sf_q.pop_front());
         end else begin
            check("rnd_lo_code", lo[31:24], 8'd64);
         end
      end
      check("rnd_words_left", words.size(), 0);
      check("rnd_hb_left", hb_q.size(), 0);
      check("rnd_sf_left", sf_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
